prog_freq_divider: RTL

- Runtime-programmable clock-enable divider; successor to the fixed two-value toggling divider.
- Produces a registered square-ish output with independently programmable high and low phase lengths, each WIDTH bits.
- New settings arrive through a valid/ready config port and take effect only at a period boundary, so the output never glitches.
- Sits beside timing/PWM logic; divider_out is a data-path enable/strobe, not a clock.

---
 rtl/freq_div_pkg.sv | 20 ++
 rtl/div_cfg_shadow.sv | 69 ++++++
 rtl/prog_freq_divider.sv | 115 +++++++++++
 3 files changed

// File: rtl/freq_div_pkg.sv
// Shared types and reset defaults for the programmable divider.
// Exports div_state_t, div_cfg_t and the default phase lengths.
package freq_div_pkg;

   localparam int CFG_W      = 16;
   localparam int DEF_HIGH_C = 18;
   localparam int DEF_LOW_C  = 866;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HIGH = 2'd1,
      LOW  = 2'd2
   } div_state_t;

   typedef struct packed {
      logic [CFG_W-1:0] high;
      logic [CFG_W-1:0] low;
   } div_cfg_t;

endpackage

// File: rtl/div_cfg_shadow.sv
// Config shadow: one-deep pending slot plus the active phase lengths.
// Ports: clk, rst, cfg_valid/cfg_ready/cfg_high/cfg_low handshake,
//        apply (period start), cfg_applied strobe, active_high/low,
//        next_high (high length the starting period will use).
module div_cfg_shadow
   import freq_div_pkg::*;
#(
   parameter int WIDTH    = 16,
   parameter int DEF_HIGH = DEF_HIGH_C,
   parameter int DEF_LOW  = DEF_LOW_C
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [WIDTH-1:0] cfg_high,
   input  logic [WIDTH-1:0] cfg_low,
   input  logic             apply,
   output logic             cfg_applied,
   output logic [WIDTH-1:0] active_high,
   output logic [WIDTH-1:0] active_low,
   output logic [WIDTH-1:0] next_high
);

   localparam logic [WIDTH-1:0] DH  = WIDTH'(DEF_HIGH);
   localparam logic [WIDTH-1:0] DL  = WIDTH'(DEF_LOW);
   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   logic             pend_v;
   logic [WIDTH-1:0] pend_high;
   logic [WIDTH-1:0] pend_low;
   logic             accept;
   logic [WIDTH-1:0] clamp_high;
   logic [WIDTH-1:0] clamp_low;

   assign cfg_ready  = ~pend_v;
   assign accept     = cfg_valid & ~pend_v;
   // a zero length would stall the counter, so it is stored as one
   assign clamp_high = (cfg_high == '0) ? ONE : cfg_high;
   assign clamp_low  = (cfg_low  == '0) ? ONE : cfg_low;
   // the FSM loads the counter in the same edge the pending slot is applied
   assign next_high  = pend_v ? pend_high : active_high;

   // accept needs an empty slot and apply needs a full one, so they
   // never fire on the same edge
   always_ff @(posedge clk) begin
      if (rst) begin
         pend_v      <= 1'b0;
         pend_high   <= '0;
         pend_low    <= '0;
         active_high <= DH;
         active_low  <= DL;
         cfg_applied <= 1'b0;
      end else begin
         cfg_applied <= 1'b0;
         if (accept) begin
            pend_v    <= 1'b1;
            pend_high <= clamp_high;
            pend_low  <= clamp_low;
         end else if (apply && pend_v) begin
            pend_v      <= 1'b0;
            active_high <= pend_high;
            active_low  <= pend_low;
            cfg_applied <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/prog_freq_divider.sv
// Runtime-programmable clock-enable divider with glitch-free reconfig.
// Ports: clk, rst, en, cfg handshake, divider_out, rise_pulse, cfg_applied.
module prog_freq_divider
   import freq_div_pkg::*;
#(
   parameter int WIDTH    = 16,
   parameter int DEF_HIGH = DEF_HIGH_C,
   parameter int DEF_LOW  = DEF_LOW_C
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [WIDTH-1:0] cfg_high,
   input  logic [WIDTH-1:0] cfg_low,
   output logic             divider_out,
   output logic             rise_pulse,
   output logic             cfg_applied
);

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   div_state_t       state;
   div_state_t       state_nx;
   logic [WIDTH-1:0] cnt;
   logic [WIDTH-1:0] cnt_nx;
   logic             cnt_zero;
   logic             start;
   logic             out_nx;
   logic             rise_nx;
   logic [WIDTH-1:0] active_high;
   logic [WIDTH-1:0] active_low;
   logic [WIDTH-1:0] next_high;

   div_cfg_shadow #(
      .WIDTH    (WIDTH),
      .DEF_HIGH (DEF_HIGH),
      .DEF_LOW  (DEF_LOW)
   ) u_shadow (
      .clk         (clk),
      .rst         (rst),
      .cfg_valid   (cfg_valid),
      .cfg_ready   (cfg_ready),
      .cfg_high    (cfg_high),
      .cfg_low     (cfg_low),
      .apply       (start),
      .cfg_applied (cfg_applied),
      .active_high (active_high),
      .active_low  (active_low),
      .next_high   (next_high)
   );

   assign cnt_zero = (cnt == '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= '0;
         divider_out <= 1'b0;
         rise_pulse  <= 1'b0;
      end else begin
         state       <= state_nx;
         cnt         <= cnt_nx;
         divider_out <= out_nx;
         rise_pulse  <= rise_nx;
      end
   end

   // start marks the edge a new period begins; lengths load as len-1
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      start    = 1'b0;
      if (!en) begin
         state_nx = IDLE;
         cnt_nx   = '0;
      end else begin
         unique case (state)
            IDLE: begin
               start    = 1'b1;
               state_nx = HIGH;
               cnt_nx   = next_high - ONE;
            end
            HIGH: begin
               if (cnt_zero) begin
                  state_nx = LOW;
                  cnt_nx   = active_low - ONE;
               end else begin
                  cnt_nx = cnt - ONE;
               end
            end
            LOW: begin
               if (cnt_zero) begin
                  start    = 1'b1;
                  state_nx = HIGH;
                  cnt_nx   = next_high - ONE;
               end else begin
                  cnt_nx = cnt - ONE;
               end
            end
            default: begin
               state_nx = IDLE;
               cnt_nx   = '0;
            end
         endcase
      end
   end

   always_comb begin
      out_nx  = (state_nx == HIGH);
      rise_nx = start;
   end

endmodule
